md_ctrl: RTL and testbench
==========================

# md_ctrl

Multiply/divide sequencer for the five-stage MIPS32 pipeline. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage and starts the external multi-cycle mul/div datapath. Counts its latency, generates HI/LO write enables at completion, and stalls F/D/E while a HI/LO consumer or another MD op waits on a busy unit. Sits beside the hazard/forward logic. Its stall output ORs into the pipeline freeze.

## Interface
- MULT_CYCLES, 5: multiply latency in busy cycles (≥1)
- DIV_CYCLES, 32: divide latency in busy cycles (≥1)
- CNT_W, 6: counter width; must hold max(MULT_CYCLES, DIV_CYCLES)-1
- clk  in  1  single clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- E_valid  in  1  E-stage instruction valid
- md_op_E  in  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo; 111 treated as none
- hilo_read_E  in  1  MFHI/MFLO in E
- flush  in  1  exception/eret flush of the pipeline
- stall_E  out  1  freeze F/D/E this cycle
- md_start  out  1  one-cycle start pulse to datapath (registered)
- md_is_div  out  1  latched op class, valid while busy
- md_signed  out  1  latched signedness, valid while busy
- md_abort  out  1  one-cycle pulse: datapath discards its operation
- hilo_we  out  2  [1]=HI, [0]=LO write enable
- busy  out  1  state != IDLE

## Operation
- States: IDLE, BUSY. Counter cnt[CNT_W-1:0].
- accept = IDLE & E_valid & op∈{mult,multu,div,divu} & !flush.
- accept → BUSY. cnt loads MULT_CYCLES-1 or DIV_CYCLES-1. md_is_div and md_signed latch from op.
- The accepted op itself is not stalled and leaves E normally.
- BUSY & cnt≠0 → cnt−1.
- BUSY & cnt==0 & !flush → hilo_we=11 this cycle (combinational), → IDLE.
- BUSY & flush (any cnt, including 0) → IDLE, md_abort=1, hilo_we=00. Flush wins over completion.
- stall_E = BUSY & E_valid & (op≠none | hilo_read_E) & !flush. Stalled op is re-evaluated every cycle.
- It is accepted in the first IDLE cycle.
- IDLE & E_valid & mthi & !flush → hilo_we=10. mtlo → hilo_we=01. No state change.
- IDLE & mfhi/mflo: no stall. HI/LO are read directly.
- md_start registered: 1 in the cycle after accept, else 0.
- Reset (async, any time, incl. mid-operation) → IDLE, cnt=0, all outputs 0. No pending write survives.

## Timing
- Accept at edge ending cycle T. md_start=1 and busy=1 in cycle T+1.
- Busy cycles are T+1 .. T+N (N = MULT_CYCLES or DIV_CYCLES). hilo_we=11 in cycle T+N.
- IDLE in cycle T+N+1.
- A dependent MFHI entering E at T+1 stalls during T+1..T+N. It executes in T+N+1 and reads the value written at the end of T+N.
- Back-to-back MD op: the second is accepted in T+N+1. Its md_start is in T+N+2.
- md_abort: asserted in the flush cycle only.
- No combinational path from flush to md_start.

## Structure
- Shared package md_pkg: md_op_E encodings (MD_NONE…MD_MTLO), state encoding (ST_IDLE, ST_BUSY), default latency constants.
- Optional sub-module md_cnt: loadable down-counter with load, dec and zero flag, CNT_W wide.
- Everything else stays in md_ctrl.

## Test plan
- mult at T, mfhi in E at T+1 (defaults) → md_start at T+1, stall_E 1 for T+1..T+5, hilo_we=11 at T+5, stall_E 0 at T+6.
- divu with no consumers → busy for exactly 32 cycles, single hilo_we=11 pulse at 32nd busy cycle, stall_E never 1.
- mthi in IDLE → hilo_we=10 same cycle, busy stays 0. mtlo while BUSY → stall_E=1 until IDLE, then hilo_we=01.
- div accepted, flush at 10th busy cycle → md_abort=1 that cycle, IDLE next, no hilo_we. Flush coinciding with cnt==0 → hilo_we=00.
- resetn low at 3rd busy cycle of mult → busy, stall_E, hilo_we, md_start 0 immediately (async). After release, mfhi in E proceeds without stall.
- mult then div back-to-back in E → div stalled 5 cycles, accepted in the IDLE cycle, md_is_div=1 for its 32 busy cycles.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the MIPS32 multiply/divide sequencer: op encodings,
// FSM state encoding, default latencies and op-class helpers.
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'b000,
    MD_MULT  = 3'b001,
    MD_MULTU = 3'b010,
    MD_DIV   = 3'b011,
    MD_DIVU  = 3'b100,
    MD_MTHI  = 3'b101,
    MD_MTLO  = 3'b110,
    MD_RSVD  = 3'b111
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 32;
  localparam int MD_CNT_W       = 6;

  // Ops that occupy the multi-cycle datapath
  function automatic logic is_md_op(input md_op_e op);
    logic r;
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_div_op(input md_op_e op);
    logic r;
    case (op)
      MD_DIV, MD_DIVU: r = 1'b1;
      default:         r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_signed_op(input md_op_e op);
    logic r;
    case (op)
      MD_MULT, MD_DIV: r = 1'b1;
      default:         r = 1'b0;
    endcase
    return r;
  endfunction

  // Any op that must wait for the unit; MD_RSVD behaves like MD_NONE
  function automatic logic is_active_op(input md_op_e op);
    logic r;
    case (op)
      MD_NONE, MD_RSVD: r = 1'b0;
      default:          r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/md_ctrl_if.sv
// E-stage <-> mul/div sequencer signal bundle. The pipeline side is master,
// the sequencer is slave.
interface md_ctrl_if;
  logic       E_valid;
  logic [2:0] md_op_E;
  logic       hilo_read_E;
  logic       flush;
  logic       stall_E;
  logic       md_start;
  logic       md_is_div;
  logic       md_signed;
  logic       md_abort;
  logic [1:0] hilo_we;
  logic       busy;

  modport master (
    output E_valid, md_op_E, hilo_read_E, flush,
    input  stall_E, md_start, md_is_div, md_signed, md_abort, hilo_we, busy
  );

  modport slave (
    input  E_valid, md_op_E, hilo_read_E, flush,
    output stall_E, md_start, md_is_div, md_signed, md_abort, hilo_we, busy
  );
endinterface

// File: rtl/md_cnt.sv
// Loadable down-counter with saturating decrement and zero flag, tracking
// the remaining busy cycles of the mul/div datapath.
module md_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_r;

  // Load has priority; decrement saturates at zero
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != {CNT_W{1'b0}})) begin
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer: starts the external datapath, counts its latency,
// raises HI/LO write enables and freezes F/D/E while the unit is busy.
module md_ctrl
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES,
  parameter int CNT_W       = MD_CNT_W
) (
  input  logic       clk,
  input  logic       resetn,
  md_ctrl_if.slave   bus
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  md_state_e        state_r;
  logic             start_r;
  logic             is_div_r;
  logic             signed_r;
  md_op_e           op_s;
  logic             accept_s;
  logic             done_s;
  logic             abort_s;
  logic             stall_s;
  logic [1:0]       we_s;
  logic             zero_s;
  logic             dec_s;
  logic [CNT_W-1:0] load_val_s;

  assign op_s = md_op_e'(bus.md_op_E);

  // Next-step decode; flush overrides both acceptance and completion
  always_comb begin
    accept_s   = 1'b0;
    done_s     = 1'b0;
    abort_s    = 1'b0;
    stall_s    = 1'b0;
    we_s       = 2'b00;
    dec_s      = 1'b0;
    load_val_s = is_div_op(op_s) ? DIV_LOAD : MULT_LOAD;
    if (state_r == ST_IDLE) begin
      accept_s = bus.E_valid && is_md_op(op_s) && !bus.flush;
      if (bus.E_valid && !bus.flush && (op_s == MD_MTHI)) begin
        we_s = 2'b10;
      end else if (bus.E_valid && !bus.flush && (op_s == MD_MTLO)) begin
        we_s = 2'b01;
      end else begin
        we_s = 2'b00;
      end
    end else begin
      abort_s = bus.flush;
      done_s  = zero_s && !bus.flush;
      dec_s   = !bus.flush;
      stall_s = bus.E_valid && (is_active_op(op_s) || bus.hilo_read_E) && !bus.flush;
      we_s    = done_s ? 2'b11 : 2'b00;
    end
  end

  md_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .resetn   (resetn),
    .load     (accept_s),
    .load_val (load_val_s),
    .dec      (dec_s),
    .zero     (zero_s)
  );

  // Sequencer FSM with registered start pulse and latched op class
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r  <= ST_IDLE;
      start_r  <= 1'b0;
      is_div_r <= 1'b0;
      signed_r <= 1'b0;
    end else begin
      start_r <= accept_s;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r  <= ST_BUSY;
            is_div_r <= is_div_op(op_s);
            signed_r <= is_signed_op(op_s);
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (bus.flush || zero_s) begin
            state_r  <= ST_IDLE;
            is_div_r <= 1'b0;
            signed_r <= 1'b0;
          end else begin
            state_r  <= ST_BUSY;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          is_div_r <= 1'b0;
          signed_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stall_E   = stall_s;
  assign bus.md_start  = start_r;
  assign bus.md_is_div = is_div_r;
  assign bus.md_signed = signed_r;
  assign bus.md_abort  = abort_s;
  assign bus.hilo_we   = we_s;
  assign bus.busy      = (state_r == ST_BUSY);

endmodule

// File: tb/tb_md_ctrl.sv
// Directed scoreboard bench for md_ctrl at default latencies (mult 5, div 32).
module tb_md_ctrl;
  import md_pkg::*;

  logic clk;
  logic resetn;
  md_ctrl_if bus();

  md_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [1:0] we;
    logic       stall;
    logic       start;
    logic       abort;
    logic       busy;
    logic       cls;
    logic       isd;
    logic       sgn;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input string name, input logic [1:0] obs, input logic [1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s.%s observed=%0b expected=%0b", tag, name, obs, expv);
    end
  endtask

  task automatic push(input string tag, input logic [1:0] we, input logic stall, input logic start,
                      input logic abort, input logic busy, input logic cls, input logic isd, input logic sgn);
    exp_t e;
    e.tag = tag; e.we = we; e.stall = stall; e.start = start; e.abort = abort;
    e.busy = busy; e.cls = cls; e.isd = isd; e.sgn = sgn;
    sb.push_back(e);
  endtask

  task automatic check_front();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_empty observed=0 entries expected>=1");
    end else begin
      e = sb.pop_front();
      chk(e.tag, "hilo_we",  bus.hilo_we,           e.we);
      chk(e.tag, "stall_E",  {1'b0, bus.stall_E},   {1'b0, e.stall});
      chk(e.tag, "md_start", {1'b0, bus.md_start},  {1'b0, e.start});
      chk(e.tag, "md_abort", {1'b0, bus.md_abort},  {1'b0, e.abort});
      chk(e.tag, "busy",     {1'b0, bus.busy},      {1'b0, e.busy});
      if (e.cls) begin
        chk(e.tag, "md_is_div", {1'b0, bus.md_is_div}, {1'b0, e.isd});
        chk(e.tag, "md_signed", {1'b0, bus.md_signed}, {1'b0, e.sgn});
      end
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic rd, input logic fl);
    bus.E_valid = v; bus.md_op_E = op; bus.hilo_read_E = rd; bus.flush = fl;
  endtask

  // One clock cycle: drive inputs, queue expectation, compare mid-cycle
  task automatic cyc(input string tag, input logic v, input logic [2:0] op, input logic rd, input logic fl,
                     input logic [1:0] we, input logic stall, input logic start, input logic abort,
                     input logic busy, input logic cls, input logic isd, input logic sgn);
    drive(v, op, rd, fl);
    push(tag, we, stall, start, abort, busy, cls, isd, sgn);
    @(negedge clk);
    check_front();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0;
    drive(1'b0, MD_NONE, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    push("reset", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_front();
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // mult, then dependent mfhi stalls until completion
    cyc("t1_acc", 1'b1, MD_MULT, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++)
      cyc("t1_mfhi", 1'b1, MD_NONE, 1'b1, 1'b0, (i == 5) ? 2'b11 : 2'b00, 1'b1, (i == 1), 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc("t1_go", 1'b1, MD_NONE, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // divu with no consumers: 32 busy cycles, single completion pulse
    cyc("t2_acc", 1'b1, MD_DIVU, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 32; i++)
      cyc("t2_busy", 1'b0, MD_NONE, 1'b0, 1'b0, (i == 32) ? 2'b11 : 2'b00, 1'b0, (i == 1), 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc("t2_idle", 1'b0, MD_NONE, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // mthi in IDLE writes HI at once; mtlo while busy waits, then writes LO
    cyc("t3_mthi", 1'b1, MD_MTHI, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("t3_acc", 1'b1, MD_MULTU, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++)
      cyc("t3_mtlo_wait", 1'b1, MD_MTLO, 1'b0, 1'b0, (i == 5) ? 2'b11 : 2'b00, 1'b1, (i == 1), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("t3_mtlo", 1'b1, MD_MTLO, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("t3_rsvd", 1'b1, MD_RSVD, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // div flushed in its 10th busy cycle
    cyc("t4_acc", 1'b1, MD_DIV, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++)
      cyc("t4_busy", 1'b0, MD_NONE, 1'b0, 1'b0, 2'b00, 1'b0, (i == 1), 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    cyc("t4_flush", 1'b1, MD_NONE, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("t4_idle", 1'b0, MD_NONE, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // flush on the completion cycle suppresses the write
    cyc("t4b_acc", 1'b1, MD_MULT, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++)
      cyc("t4b_busy", 1'b0, MD_NONE, 1'b0, 1'b0, 2'b00, 1'b0, (i == 1), 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc("t4b_flush0", 1'b0, MD_NONE, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("t4b_idle", 1'b0, MD_NONE, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // flush in IDLE blocks acceptance and MTHI writes
    cyc("t4c_accfl", 1'b1, MD_DIV, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("t4c_mthifl", 1'b1, MD_MTHI, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // async reset in the 3rd busy cycle of a mult
    cyc("t5_acc", 1'b1, MD_MULT, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 2; i++)
      cyc("t5_busy", 1'b0, MD_NONE, 1'b0, 1'b0, 2'b00, 1'b0, (i == 1), 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, MD_NONE, 1'b1, 1'b0);
    #1;
    push("t5_pre_rst", 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check_front();
    resetn = 1'b0;
    #1;
    push("t5_rst", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_front();
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    cyc("t5_mfhi", 1'b1, MD_NONE, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // async reset while md_start is high
    cyc("t5b_acc", 1'b1, MD_DIVU, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, MD_NONE, 1'b0, 1'b0);
    #1;
    push("t5b_pre_rst", 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_front();
    resetn = 1'b0;
    #1;
    push("t5b_rst", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_front();
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // mult then div back-to-back: div waits 5 cycles, accepted in the IDLE cycle
    cyc("t6_mult", 1'b1, MD_MULT, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++)
      cyc("t6_div_wait", 1'b1, MD_DIV, 1'b0, 1'b0, (i == 5) ? 2'b11 : 2'b00, 1'b1, (i == 1), 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc("t6_div_acc", 1'b1, MD_DIV, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 32; i++)
      cyc("t6_div_busy", 1'b0, MD_NONE, 1'b0, 1'b0, (i == 32) ? 2'b11 : 2'b00, 1'b0, (i == 1), 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    cyc("t6_idle", 1'b0, MD_NONE, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
